// File: rtl/spi_resp_pkg.sv
// Shared constants, state encoding and command-field helpers for the SPI register responder.
package spi_resp_pkg;

    localparam int REG_COUNT    = 32;
    localparam int ADDR_W       = 5;

    // Command byte layout: {addr[4:0], 1'b0, dir, 1'b0}
    localparam int CMD_ADDR_MSB = 7;
    localparam int CMD_ADDR_LSB = 3;
    localparam int CMD_DIR_BIT  = 1;

    localparam logic DIR_WRITE  = 1'b1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_CMD  = S_CMD,
        ST_DATA = S_DATA
    } state_e;

    function automatic logic [ADDR_W-1:0] cmd_addr(input logic [7:0] cmd);
        return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
    endfunction

    function automatic logic cmd_dir(input logic [7:0] cmd);
        return cmd[CMD_DIR_BIT];
    endfunction

endpackage

// File: rtl/spi_responder_if.sv
// SPI pin bundle between an SPI master and the responder; signal names match the device pins.
interface spi_responder_if;

    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;
    logic MISO_oe;

    modport master (
        output SS_n, SCLK, MOSI,
        input  MISO, MISO_oe
    );

    modport slave (
        input  SS_n, SCLK, MOSI,
        output MISO, MISO_oe
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous input, plus rise/fall detect on the synchronized value.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o =  sync_q & ~prev_q;
    assign fall_o = ~sync_q &  prev_q;

endmodule

// File: rtl/spi_responder.sv
// Mode-0 SPI slave fronting a 32 x 8 register file with a fabric write port and write notification.
// Build option: define SPI_RESP_AUTOINC_EN to step the address after every data byte.
module spi_responder
    import spi_resp_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    spi_responder_if.slave    spi,
    input  logic              fab_we,
    input  logic [ADDR_W-1:0] fab_addr,
    input  logic [7:0]        fab_wdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    logic ss_rise, ss_fall;
    logic sclk_rise, sclk_fall;
    logic mosi_sync;

    // Select synchronizer resets to the "selected" level so that a master still holding
    // SS_n low across Reset produces no falling edge; only a fresh select can start a frame.
    spi_sync_edge #(.RESET_VAL(1'b0)) u_ss_sync (
        .Clk     (Clk),
        .Reset   (Reset),
        .async_i (spi.SS_n),
        .sync_o  (),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .Clk     (Clk),
        .Reset   (Reset),
        .async_i (spi.SCLK),
        .sync_o  (),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi_sync (
        .Clk     (Clk),
        .Reset   (Reset),
        .async_i (spi.MOSI),
        .sync_o  (mosi_sync),
        .rise_o  (),
        .fall_o  ()
    );

    logic [7:0]        regs_q [REG_COUNT];

    state_e            state_q,     state_d;
    logic [2:0]        bit_cnt_q,   bit_cnt_d;
    logic [7:0]        tx_q,        tx_d;
    logic [6:0]        rx_q,        rx_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic              dir_q,       dir_d;
    logic              miso_q,      miso_d;
    logic              oe_q,        oe_d;
    logic              stb_q,       stb_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [7:0]        wr_data_q,   wr_data_d;

    logic [7:0]        rx_byte;
    logic              byte_done;
    logic              spi_we;
    logic [ADDR_W-1:0] addr_next;

    assign rx_byte   = {rx_q, mosi_sync};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

`ifdef SPI_RESP_AUTOINC_EN
    assign addr_next = addr_q + ADDR_W'(1);
`else
    assign addr_next = addr_q;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        addr_d    = addr_q;
        dir_d     = dir_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        stb_d     = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        spi_we    = 1'b0;

        if (ss_rise) begin
            // Deselect wins over any coincident SCLK edge; a partial byte is dropped.
            state_d   = ST_IDLE;
            oe_d      = 1'b0;
            miso_d    = 1'b0;
            bit_cnt_d = 3'd0;
            rx_d      = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state_d   = ST_CMD;
                        oe_d      = 1'b1;
                        tx_d      = regs_q[0];
                        miso_d    = regs_q[0][7];
                        bit_cnt_d = 3'd0;
                        rx_d      = '0;
                    end
                end
                ST_CMD, ST_DATA: begin
                    if (sclk_rise) begin
                        rx_d      = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (byte_done && state_q == ST_CMD) begin
                            addr_d  = cmd_addr(rx_byte);
                            dir_d   = cmd_dir(rx_byte);
                            tx_d    = regs_q[cmd_addr(rx_byte)];
                            state_d = ST_DATA;
                        end else if (byte_done) begin
                            if (dir_q == DIR_WRITE) begin
                                spi_we    = 1'b1;
                                stb_d     = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = rx_byte;
                            end
                            addr_d = addr_next;
                            tx_d   = regs_q[addr_next];
                        end
                    end else if (sclk_fall) begin
                        // Counter at zero means a fresh byte was just loaded: present its MSB.
                        if (bit_cnt_q == 3'd0) begin
                            miso_d = tx_q[7];
                        end else begin
                            miso_d = tx_q[6];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            tx_q      <= '0;
            rx_q      <= '0;
            addr_q    <= '0;
            dir_q     <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            stb_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            addr_q    <= addr_d;
            dir_q     <= dir_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            stb_q     <= stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // NOTE: the register file must come up cleared, so it is reset explicitly rather than left
    // to power-up state; the SPI write is placed last so it wins a same-address collision.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (fab_we) begin
                regs_q[fab_addr] <= fab_wdata;
            end
            if (spi_we) begin
                regs_q[addr_q] <= rx_byte;
            end
        end
    end

    assign spi.MISO    = miso_q;
    assign spi.MISO_oe = oe_q;
    assign wr_strobe   = stb_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;

endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 SHALL have port Clk, input, 1, single 50 MHz system clock; all state changes on rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port SS_n, input, 1, asynchronous SPI select from the master, active low.
REQ-004 SHALL have port SCLK, input, 1, asynchronous SPI mode-0 clock (CPOL=0, CPHA=0).
REQ-005 SHALL have port MOSI, input, 1, asynchronous master-out data, MSB first.
REQ-006 SHALL have port MISO, output, 1, slave-out data, MSB first.
REQ-007 SHALL have port MISO_oe, output, 1, high while selected; top level tri-states MISO when low.
REQ-008 SHALL have ports fab_we (input, 1), fab_addr (input, 5) and fab_wdata (input, 8): fabric-side register write.
REQ-009 SHALL have ports wr_strobe (output, 1), wr_addr (output, 5) and wr_data (output, 8): one-cycle notification of an SPI register write.

Function
REQ-010 SHALL hold a 32 x 8 register file; register 0 is the status byte.
REQ-011 SHALL pass SS_n, SCLK and MOSI through 2-flop synchronizers and detect SCLK edges on the synchronized signal; the supported SCLK is at most Clk/8.
REQ-012 SHALL run an FSM with states IDLE, CMD and DATA.
REQ-013 In IDLE, synchronized SS_n falling SHALL assert MISO_oe, load reg[0] into the TX shifter, drive its bit 7 on MISO, and enter CMD.
REQ-014 Each detected SCLK rise SHALL shift synchronized MOSI into the RX shifter and increment a 3-bit bit counter.
REQ-015 Each detected SCLK fall SHALL present the next TX bit on MISO.
REQ-016 The command byte is {addr[4:0], 1'b0, dir, 1'b0}, with dir=1 meaning write; on its 8th rise the FSM SHALL latch addr and dir, load reg[addr] into the TX shifter for the next byte, and enter DATA.
REQ-017 In DATA with dir=1, each completed byte SHALL write reg[addr] and pulse wr_strobe for exactly one cycle on the following clock, with wr_addr and wr_data valid in that cycle.
REQ-018 In DATA with dir=0, the master's MOSI bytes SHALL be ignored, and reg[addr] SHALL be reloaded into the TX shifter after each byte.
REQ-019 Without the address-increment feature, consecutive data bytes SHALL access the same addr.
REQ-020 Synchronized SS_n rising in any state SHALL abort: discard a partial byte, deassert MISO_oe, drive MISO 0, clear the bit counter, and enter IDLE.
REQ-021 A fabric write SHALL update reg[fab_addr] in the same cycle it is presented.
REQ-022 A fabric write and an SPI write to the same address in the same cycle SHALL resolve to the SPI data.
REQ-023 A fabric write to the address being read SHALL be visible on MISO from the next byte boundary, never mid-byte.
REQ-024 An SCLK rise and an SS_n rise detected in the same cycle SHALL be treated as an abort.

Reset
REQ-025 Reset SHALL clear all 32 registers, the shifters and the bit counter, set state IDLE, and drive MISO=0, MISO_oe=0 and wr_strobe=0, with wr_addr and wr_data at 0.
REQ-026 Reset asserted mid-transfer SHALL take effect on the next edge regardless of SS_n; after release, the responder SHALL wait for a fresh SS_n falling edge.

Configuration
REQ-027 With SPI_RESP_AUTOINC_EN defined, addr SHALL increment after every DATA byte, wrapping 31->0.
REQ-028 Without SPI_RESP_AUTOINC_EN, addr SHALL stay fixed for the whole transaction.

Structure
REQ-029 Package spi_resp_pkg SHALL hold the state enum, REG_COUNT=32, ADDR_W=5, the command-bit position constants, and DIR_WRITE=1.
REQ-030 Sub-module spi_sync_edge SHALL hold one 2-flop synchronizer plus rise/fall detect and be instantiated for SS_n, SCLK and MOSI (MOSI edges unused).

Verification
REQ-031 Write: after reset, command 0x8A then data 0x5A -> reg[17]=0x5A; wr_strobe high exactly 1 cycle with wr_addr=17 and wr_data=0x5A.
REQ-032 Read: fabric writes reg[17]=0xC3, then command 0x88 plus one dummy byte -> MISO returns the reg[0] value during the command byte and 0xC3 during the data byte.
REQ-033 Abort: command 0x8A, then 4 data bits, then SS_n high -> no wr_strobe, reg[17] unchanged, MISO_oe=0 within 3 cycles.
REQ-034 Collision: an SPI write of 0x11 and a fabric write of 0x22 both to reg[5] in the same cycle -> reg[5]=0x11.
REQ-035 Autoinc: with SPI_RESP_AUTOINC_EN, a write starting at addr 31 with data 0xAA then 0xBB -> reg[31]=0xAA and reg[0]=0xBB; without the macro -> reg[31]=0xBB.
REQ-036 Reset mid-transfer: Reset pulsed during the command byte -> all outputs at reset values; the next full transaction completes correctly.
